i2osp_serializer: RTL and testbench

//  RSA output stage: I2OSP (RFC 8017 s4.1) on the mod_exp result.
//  - Takes an INT_W-bit integer and emits an OCTET_LEN-byte big-endian octet string, one byte per beat.
//  - Sits directly downstream of the decrypt/mod_exp datapath and feeds the message/transport byte stream.
//  - Flags "integer too large" instead of truncating.

---
 rtl/i2osp_pkg.sv | 17 +
 rtl/i2osp_serializer_if.sv | 44 ++++
 rtl/i2osp_serializer.sv | 106 ++++++++++
 tb/tb_i2osp_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2osp_pkg.sv
// I2OSP serializer shared types: FSM state, octet width, length helper.
// Optional runtime length selected by I2OSP_RUNTIME_LEN_EN.
package i2osp_pkg;

  localparam int OCTET_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    ERR
  } state_t;

  function automatic int octets_to_bits(input int len);
    return len * OCTET_W;
  endfunction

endpackage

// File: rtl/i2osp_serializer_if.sv
// Integer-in / octet-stream-out handshake bundle for the I2OSP serializer.
// I2OSP_RUNTIME_LEN_EN adds the per-conversion xlen field.
import i2osp_pkg::*;

interface i2osp_serializer_if #(
  parameter int INT_W = 2048
`ifdef I2OSP_RUNTIME_LEN_EN
  , parameter int CNT_W = 16
`endif
);

  logic               in_valid;
  logic               in_ready;
  logic [INT_W-1:0]   in_int;
`ifdef I2OSP_RUNTIME_LEN_EN
  logic [CNT_W-1:0]   xlen;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [OCTET_W-1:0] out_byte;
  logic               out_last;
  logic               err;

`ifdef I2OSP_RUNTIME_LEN_EN
  modport master (
    output in_valid, in_int, xlen, out_ready,
    input  in_ready, out_valid, out_byte, out_last, err
  );
  modport slave (
    input  in_valid, in_int, xlen, out_ready,
    output in_ready, out_valid, out_byte, out_last, err
  );
`else
  modport master (
    output in_valid, in_int, out_ready,
    input  in_ready, out_valid, out_byte, out_last, err
  );
  modport slave (
    input  in_valid, in_int, out_ready,
    output in_ready, out_valid, out_byte, out_last, err
  );
`endif

endinterface

// File: rtl/i2osp_serializer.sv
// I2OSP: integer -> big-endian octet string, one octet per beat.
// I2OSP_RUNTIME_LEN_EN: xLen taken from bus.xlen at accept.
import i2osp_pkg::*;

module i2osp_serializer #(
  parameter int INT_W     = 2048,
  parameter int OCTET_LEN = 256,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  i2osp_serializer_if.slave bus
);

  localparam int SR_W = octets_to_bits(OCTET_LEN);
  localparam int XW   = (INT_W > SR_W) ? INT_W : SR_W;

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_in;
  logic [XW-1:0]    x_ext;
  logic [SR_W-1:0]  x_load;
  logic             bad;
  logic             accept;
  logic             beat;

  assign x_ext        = XW'(bus.in_int);
  assign accept       = bus.in_valid && bus.in_ready;
  assign beat         = bus.out_valid && bus.out_ready;
  assign bus.out_byte = sr[SR_W-1 -: OCTET_W];

`ifdef I2OSP_RUNTIME_LEN_EN
  logic [31:0] xl32;
  logic [31:0] pad_bits;

  assign len_in   = bus.xlen;
  assign xl32     = 32'(bus.xlen);
  assign pad_bits = (32'(OCTET_LEN) - xl32) << 3;
  // short strings are left-aligned so the top octet is always first
  assign x_load   = SR_W'(x_ext) << pad_bits;
  assign bad      = (xl32 == 32'd0)
                 || (xl32 > 32'(OCTET_LEN))
                 || (|(x_ext >> (xl32 << 3)));
`else
  assign len_in = CNT_W'(OCTET_LEN);
  assign x_load = SR_W'(x_ext);
  assign bad    = |(x_ext >> SR_W);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      sr            <= '0;
      cnt           <= '0;
      len_q         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          bus.err      <= 1'b0;
          if (accept) begin
            bus.in_ready <= 1'b0;
            cnt          <= '0;
            len_q        <= len_in;
            if (bad) begin
              state   <= ERR;
              bus.err <= 1'b1;
            end else begin
              state         <= STREAM;
              sr            <= x_load;
              bus.out_valid <= 1'b1;
              bus.out_last  <= (len_in == CNT_W'(1));
            end
          end
        end
        STREAM: begin
          if (beat) begin
            sr           <= sr << OCTET_W;
            cnt          <= cnt + 1'b1;
            // next octet index (cnt+1) is the last one
            bus.out_last <= (cnt + CNT_W'(2) == len_q);
            if (bus.out_last) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
            end
          end
        end
        ERR: begin
          state        <= IDLE;
          bus.err      <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2osp_serializer.sv
// Directed bench: 256-octet, 4-octet and (with I2OSP_RUNTIME_LEN_EN)
// runtime-length serializer instances.
module tb_i2osp_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef I2OSP_RUNTIME_LEN_EN
  i2osp_serializer_if #(.INT_W(2048), .CNT_W(16)) b_if ();
  i2osp_serializer_if #(.INT_W(64), .CNT_W(16)) s_if ();
  i2osp_serializer_if #(.INT_W(64), .CNT_W(16)) r_if ();

  i2osp_serializer #(.INT_W(64), .OCTET_LEN(8), .CNT_W(16)) u_rt (
    .clk(clk), .reset(reset), .bus(r_if.slave)
  );
`else
  i2osp_serializer_if #(.INT_W(2048)) b_if ();
  i2osp_serializer_if #(.INT_W(64)) s_if ();
`endif

  i2osp_serializer #(.INT_W(2048), .OCTET_LEN(256), .CNT_W(16)) u_big (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  i2osp_serializer #(.INT_W(64), .OCTET_LEN(4), .CNT_W(16)) u_sml (
    .clk(clk), .reset(reset), .bus(s_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s_q[$];
  int s_lastpos;
  int s_unstable;

  // collect one string from the small instance; rpat drives out_ready
  task automatic s_collect(input int budget, input logic [31:0] rpat);
    logic [7:0] hb;
    logic hv;
    logic hl;
    s_q.delete();
    s_lastpos = -1;
    s_unstable = 0;
    hv = 1'b0;
    hb = '0;
    hl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      s_if.out_ready = rpat[c % 32];
      if (hv && (!s_if.out_valid || s_if.out_byte != hb ||
                 s_if.out_last != hl))
        s_unstable++;
      hv = s_if.out_valid && !s_if.out_ready;
      hb = s_if.out_byte;
      hl = s_if.out_last;
      if (s_if.out_valid && s_if.out_ready) begin
        s_q.push_back(s_if.out_byte);
        if (s_if.out_last) s_lastpos = s_q.size() - 1;
      end
      step();
      if (s_lastpos >= 0) break;
    end
  endtask

  function automatic logic [63:0] s_pack();
    logic [63:0] v;
    v = '0;
    foreach (s_q[i]) v = {v[55:0], s_q[i]};
    return v;
  endfunction

  int nz;
  int lastcnt;
  int lastpos;
  int novalid;
  int vcnt;
  logic [7:0] b254;
  logic [7:0] b255;

  initial begin
    b_if.in_valid = 1'b0; b_if.in_int = '0; b_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_int = '0; s_if.out_ready = 1'b0;
`ifdef I2OSP_RUNTIME_LEN_EN
    b_if.xlen = 16'd256;
    s_if.xlen = 16'd4;
    r_if.in_valid = 1'b0; r_if.in_int = '0; r_if.out_ready = 1'b0;
    r_if.xlen = 16'd8;
`endif
    reset = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", s_if.in_ready, 0);
    chk("rst_out_valid", s_if.out_valid, 0);
    chk("rst_out_last", s_if.out_last, 0);
    chk("rst_err", s_if.err, 0);
    chk("rst_out_byte", s_if.out_byte, 0);
    chk("rst_big_ready", b_if.in_ready, 0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", s_if.in_ready, 1);
    chk("post_rst_big_ready", b_if.in_ready, 1);

    // 1: 256-octet string of 0x0102
    b_if.in_int = 2048'h0102;
    b_if.in_valid = 1'b1;
    b_if.out_ready = 1'b1;
    step();
    b_if.in_valid = 1'b0;
    nz = 0; lastcnt = 0; lastpos = -1; novalid = 0;
    b254 = '0; b255 = '0;
    for (int i = 0; i < 256; i++) begin
      if (!b_if.out_valid) novalid++;
      if (i < 254 && b_if.out_byte != 8'h00) nz++;
      if (i == 254) b254 = b_if.out_byte;
      if (i == 255) b255 = b_if.out_byte;
      if (b_if.out_last) begin
        lastcnt++;
        lastpos = i;
      end
      step();
    end
    chk("t1_valid_gaps", novalid, 0);
    chk("t1_leading_zeros", nz, 0);
    chk("t1_byte254", b254, 8'h01);
    chk("t1_byte255", b255, 8'h02);
    chk("t1_last_count", lastcnt, 1);
    chk("t1_last_pos", lastpos, 255);
    chk("t1_done_valid", b_if.out_valid, 0);
    chk("t1_done_ready", b_if.in_ready, 1);
    b_if.in_int = 2048'hFF;
    b_if.in_valid = 1'b1;
    step();
    b_if.in_valid = 1'b0;
    chk("t1_next_accept", b_if.out_valid, 1);
    chk("t1_next_byte0", b_if.out_byte, 8'h00);

    // 2: overflow 2^32 into 4 octets
    s_if.in_int = 64'h1_0000_0000;
    s_if.in_valid = 1'b1;
    s_if.out_ready = 1'b1;
    step();
    s_if.in_valid = 1'b0;
    chk("t2_err_pulse", s_if.err, 1);
    chk("t2_no_valid", s_if.out_valid, 0);
    chk("t2_busy", s_if.in_ready, 0);
    step();
    chk("t2_err_clear", s_if.err, 0);
    chk("t2_ready_after", s_if.in_ready, 1);
    chk("t2_no_valid2", s_if.out_valid, 0);

    // 3: backpressure 1,0,0,1,...
    s_if.in_int = 64'hDEADBEEF;
    s_if.in_valid = 1'b1;
    step();
    s_if.in_valid = 1'b0;
    s_collect(40, 32'h99999999);
    chk("t3_data", s_pack(), 64'hDEADBEEF);
    chk("t3_count", s_q.size(), 4);
    chk("t3_last_pos", s_lastpos, 3);
    chk("t3_stable", s_unstable, 0);
    s_if.out_ready = 1'b1;
    vcnt = 0;
    repeat (3) begin
      if (s_if.out_valid) vcnt++;
      step();
    end
    chk("t3_no_extra", vcnt, 0);

    // 4: reset after the second beat
    s_if.in_int = 64'hCAFEF00D;
    s_if.in_valid = 1'b1;
    step();
    s_if.in_valid = 1'b0;
    chk("t4_b0", s_if.out_byte, 8'hCA);
    step();
    chk("t4_b1", s_if.out_byte, 8'hFE);
    step();
    chk("t4_b2", s_if.out_byte, 8'hF0);
    reset = 1'b0;
    step();
    chk("t4_abort_valid", s_if.out_valid, 0);
    chk("t4_abort_ready", s_if.in_ready, 0);
    reset = 1'b1;
    step();
    chk("t4_rel_ready", s_if.in_ready, 1);
    chk("t4_rel_err", s_if.err, 0);
    s_if.in_int = 64'h11223344;
    s_if.in_valid = 1'b1;
    step();
    s_if.in_valid = 1'b0;
    s_collect(20, 32'hFFFFFFFF);
    chk("t4_data", s_pack(), 64'h11223344);
    chk("t4_count", s_q.size(), 4);

    // 6: in_valid held across a whole string
    s_if.in_int = 64'hA1A2A3A4;
    s_if.in_valid = 1'b1;
    step();
    s_if.in_int = 64'hB1B2B3B4;
    s_collect(20, 32'hFFFFFFFF);
    chk("t6_first", s_pack(), 64'hA1A2A3A4);
    chk("t6_first_cnt", s_q.size(), 4);
    chk("t6_gap_valid", s_if.out_valid, 0);
    chk("t6_gap_ready", s_if.in_ready, 1);
    step();
    s_if.in_valid = 1'b0;
    chk("t6_second_start", s_if.out_valid, 1);
    s_collect(40, 32'h99999999);
    chk("t6_second", s_pack(), 64'hB1B2B3B4);
    chk("t6_second_cnt", s_q.size(), 4);
    chk("t6_stable", s_unstable, 0);

`ifdef I2OSP_RUNTIME_LEN_EN
    // 5: runtime length
    r_if.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r_if.xlen = (k == 0) ? 16'd0 : 16'd9;
      r_if.in_int = 64'h5;
      r_if.in_valid = 1'b1;
      step();
      r_if.in_valid = 1'b0;
      chk("t5_len_err", r_if.err, 1);
      chk("t5_len_novalid", r_if.out_valid, 0);
      step();
      chk("t5_len_err_end", r_if.err, 0);
      chk("t5_len_novalid2", r_if.out_valid, 0);
    end
    r_if.xlen = 16'd2;
    r_if.in_int = 64'hABCD;
    r_if.in_valid = 1'b1;
    step();
    r_if.in_valid = 1'b0;
    chk("t5_b0", r_if.out_byte, 8'hAB);
    chk("t5_b0_last", r_if.out_last, 0);
    chk("t5_b0_valid", r_if.out_valid, 1);
    step();
    chk("t5_b1", r_if.out_byte, 8'hCD);
    chk("t5_b1_last", r_if.out_last, 1);
    step();
    chk("t5_done", r_if.out_valid, 0);
    chk("t5_ready", r_if.in_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
